// File: rtl/wb_pipe_if.sv
// Bundle of the MEM-side retire signals and the register-file write ports
// around the write-back stage.
interface wb_pipe_if #(
   parameter int WIDTH = 32,
   parameter int RADDR = 5
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] alu_out;
   logic [WIDTH-1:0] fpu_out;
   logic [WIDTH-1:0] bus_a;
   logic [WIDTH-1:0] fbus_a;
   logic [WIDTH-1:0] jal_out;
   logic [RADDR-1:0] rd;
   logic [RADDR-1:0] frd;
   logic             reg_wr;
   logic             freg_wr;
   logic             mem_to_reg;
   logic             mov_instr;
   logic             jal_ctrl;
   logic [1:0]       ld_size;
   logic             ld_signed;
   logic [1:0]       ld_addr_lo;
   logic             mem_rvalid;
   logic [WIDTH-1:0] mem_rdata;
   logic [WIDTH-1:0] busW;
   logic [WIDTH-1:0] fbusW;
   logic [RADDR-1:0] rw_addr;
   logic [RADDR-1:0] frw_addr;
   logic             rw_en;
   logic             frw_en;
   logic             wb_busy;

   modport master (
      output in_valid, alu_out, fpu_out, bus_a, fbus_a, jal_out, rd, frd,
             reg_wr, freg_wr, mem_to_reg, mov_instr, jal_ctrl, ld_size,
             ld_signed, ld_addr_lo, mem_rvalid, mem_rdata,
      input  in_ready, busW, fbusW, rw_addr, frw_addr, rw_en, frw_en, wb_busy
   );

   modport slave (
      input  in_valid, alu_out, fpu_out, bus_a, fbus_a, jal_out, rd, frd,
             reg_wr, freg_wr, mem_to_reg, mov_instr, jal_ctrl, ld_size,
             ld_signed, ld_addr_lo, mem_rvalid, mem_rdata,
      output in_ready, busW, fbusW, rw_addr, frw_addr, rw_en, frw_en, wb_busy
   );
endinterface

// File: rtl/wb_pipe.sv
// Registered write-back stage: selects integer/FP write data, extracts
// sub-word loads (big-endian lanes) and stalls for late memory data.
//
//   state    | meaning
//   IDLE     | ready to accept; retires non-loads and loads with data present
//   WAIT_MEM | load accepted without data; holds its fields until mem_rvalid
module wb_pipe #(
   parameter int WIDTH = 32,
   parameter int RADDR = 5
) (
   input logic    clk,
   input logic    rst_n,
   wb_pipe_if.slave bus
);
   typedef enum logic {IDLE = 1'b0, WAIT_MEM = 1'b1} state_t;

   state_t           state, stateNext;
   logic             accept, fire, useLive;

   logic [WIDTH-1:0] holdJalOut, holdBusA, holdFbusA;
   logic [RADDR-1:0] holdRd, holdFrd;
   logic             holdRegWr, holdFregWr, holdMov, holdJal, holdSigned;
   logic [1:0]       holdSize, holdAddrLo;

   logic [WIDTH-1:0] curJalOut, curBusA, curFbusA;
   logic [RADDR-1:0] curRd, curFrd;
   logic             curRegWr, curFregWr, curMov, curJal, curMemToReg, curSigned;
   logic [1:0]       curSize, curAddrLo;

   logic [WIDTH-1:0] byteShift, halfShift, ldExt, intData, fpData;
   logic [7:0]       byteVal;
   logic [15:0]      halfVal;

   assign accept      = bus.in_valid && (state == IDLE);
   assign bus.in_ready = (state == IDLE);
   assign bus.wb_busy  = (state == WAIT_MEM);

   // In IDLE the live MEM inputs drive the result; in WAIT_MEM the held load does.
   assign useLive     = (state == IDLE);
   assign curJalOut   = useLive ? bus.jal_out    : holdJalOut;
   assign curBusA     = useLive ? bus.bus_a      : holdBusA;
   assign curFbusA    = useLive ? bus.fbus_a     : holdFbusA;
   assign curRd       = useLive ? bus.rd         : holdRd;
   assign curFrd      = useLive ? bus.frd        : holdFrd;
   assign curRegWr    = useLive ? bus.reg_wr     : holdRegWr;
   assign curFregWr   = useLive ? bus.freg_wr    : holdFregWr;
   assign curMov      = useLive ? bus.mov_instr  : holdMov;
   assign curJal      = useLive ? bus.jal_ctrl   : holdJal;
   assign curMemToReg = useLive ? bus.mem_to_reg : 1'b1;
   assign curSigned   = useLive ? bus.ld_signed  : holdSigned;
   assign curSize     = useLive ? bus.ld_size    : holdSize;
   assign curAddrLo   = useLive ? bus.ld_addr_lo : holdAddrLo;

   assign fire = accept ? (!bus.mem_to_reg || bus.mem_rvalid)
                        : ((state == WAIT_MEM) && bus.mem_rvalid);

   // Lane extraction: shift the selected lane up to the MSB end, then take the top bits.
   always_comb begin
      byteShift = bus.mem_rdata << {curAddrLo, 3'b000};
      halfShift = bus.mem_rdata << {curAddrLo[1], 4'b0000};
      byteVal   = byteShift[WIDTH-1 -: 8];
      halfVal   = halfShift[WIDTH-1 -: 16];
      case (curSize)
         2'b00:   ldExt = {{(WIDTH-8){curSigned & byteVal[7]}}, byteVal};
         2'b01:   ldExt = {{(WIDTH-16){curSigned & halfVal[15]}}, halfVal};
         default: ldExt = bus.mem_rdata;
      endcase
   end

   // Write-data priority for both register files.
   always_comb begin
      intData = bus.alu_out;
      if (curJal)           intData = curJalOut;
      else if (curMov)      intData = curFbusA;
      else if (curMemToReg) intData = ldExt;
      fpData = bus.fpu_out;
      if (curMov)           fpData = curBusA;
      else if (curMemToReg) fpData = bus.mem_rdata;
   end

   // Next-state logic.
   always_comb begin
      stateNext = state;
      case (state)
         IDLE:     if (accept && bus.mem_to_reg && !bus.mem_rvalid) stateNext = WAIT_MEM;
         WAIT_MEM: if (bus.mem_rvalid) stateNext = IDLE;
         default:  stateNext = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= stateNext;
   end

   // Capture the instruction fields on accept so a stalled load can finish later.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         holdJalOut <= '0;
         holdBusA   <= '0;
         holdFbusA  <= '0;
         holdRd     <= '0;
         holdFrd    <= '0;
         holdRegWr  <= 1'b0;
         holdFregWr <= 1'b0;
         holdMov    <= 1'b0;
         holdJal    <= 1'b0;
         holdSigned <= 1'b0;
         holdSize   <= 2'b00;
         holdAddrLo <= 2'b00;
      end else if (accept) begin
         holdJalOut <= bus.jal_out;
         holdBusA   <= bus.bus_a;
         holdFbusA  <= bus.fbus_a;
         holdRd     <= bus.rd;
         holdFrd    <= bus.frd;
         holdRegWr  <= bus.reg_wr;
         holdFregWr <= bus.freg_wr;
         holdMov    <= bus.mov_instr;
         holdJal    <= bus.jal_ctrl;
         holdSigned <= bus.ld_signed;
         holdSize   <= bus.ld_size;
         holdAddrLo <= bus.ld_addr_lo;
      end
   end

   // Register-file write ports; data/address hold between writes, strobes pulse once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.busW     <= '0;
         bus.fbusW    <= '0;
         bus.rw_addr  <= '0;
         bus.frw_addr <= '0;
         bus.rw_en    <= 1'b0;
         bus.frw_en   <= 1'b0;
      end else begin
         bus.rw_en  <= 1'b0;
         bus.frw_en <= 1'b0;
         if (fire) begin
            bus.busW     <= intData;
            bus.fbusW    <= fpData;
            bus.rw_addr  <= curRd;
            bus.frw_addr <= curFrd;
            bus.rw_en    <= curRegWr && (curRd != '0);
            bus.frw_en   <= curFregWr;
         end
      end
   end
endmodule

// File: tb/tb_wb_pipe.sv
// Directed bench for wb_pipe with a transaction-level reference model and
// a per-cycle output comparison, plus literal checks at key points.
module tb_wb_pipe;
   localparam int W = 32;
   localparam int A = 5;

   logic clk;
   logic rst_n;

   wb_pipe_if #(.WIDTH(W), .RADDR(A)) bus ();

   wb_pipe #(.WIDTH(W), .RADDR(A)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct packed {
      logic [31:0] alu;
      logic [31:0] fpu;
      logic [31:0] busA;
      logic [31:0] fbusA;
      logic [31:0] jal;
      logic [4:0]  rd;
      logic [4:0]  frd;
      logic        regWr;
      logic        fregWr;
      logic        memToReg;
      logic        mov;
      logic        jalC;
      logic [1:0]  sz;
      logic        sgn;
      logic [1:0]  lo;
   } instr_t;

   int nVec = 0;
   int nMis = 0;
   bit chkOn = 0;

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      nVec++;
      if (act !== exp) begin
         nMis++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic [31:0] loadVal(input logic [1:0] sz, input logic sgn,
                                           input logic [1:0] lo, input logic [31:0] data);
      int unsigned v;
      int unsigned lane;
      case (sz)
         2'd0: begin
            lane = 32'(lo);
            v = (data >> (8 * (3 - lane))) & 32'hFF;
            if (sgn && v >= 128) v = v | 32'hFFFFFF00;
         end
         2'd1: begin
            lane = 32'(lo) / 2;
            v = (data >> (16 * (1 - lane))) & 32'hFFFF;
            if (sgn && v >= 32768) v = v | 32'hFFFF0000;
         end
         default: v = data;
      endcase
      return v;
   endfunction

   function automatic logic [31:0] intResult(input instr_t i, input logic [31:0] rdata);
      if (i.jalC)     return i.jal;
      if (i.mov)      return i.fbusA;
      if (i.memToReg) return loadVal(i.sz, i.sgn, i.lo, rdata);
      return i.alu;
   endfunction

   function automatic logic [31:0] fpResult(input instr_t i, input logic [31:0] rdata);
      if (i.mov)      return i.busA;
      if (i.memToReg) return rdata;
      return i.fpu;
   endfunction

   function automatic instr_t sampleInputs();
      instr_t i;
      i.alu = bus.alu_out;     i.fpu = bus.fpu_out;
      i.busA = bus.bus_a;      i.fbusA = bus.fbus_a;
      i.jal = bus.jal_out;     i.rd = bus.rd;       i.frd = bus.frd;
      i.regWr = bus.reg_wr;    i.fregWr = bus.freg_wr;
      i.memToReg = bus.mem_to_reg; i.mov = bus.mov_instr; i.jalC = bus.jal_ctrl;
      i.sz = bus.ld_size;      i.sgn = bus.ld_signed; i.lo = bus.ld_addr_lo;
      return i;
   endfunction

   logic [31:0] expBusW = '0, expFbusW = '0;
   logic [4:0]  expRwAddr = '0, expFrwAddr = '0;
   logic        expRwEn = 0, expFrwEn = 0;
   logic        pending = 0;
   instr_t      pendInstr = '0;
   instr_t      curI;

   // Model: pending load waits for mem_rvalid; every retirement updates the ports once.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         expBusW <= '0; expFbusW <= '0; expRwAddr <= '0; expFrwAddr <= '0;
         expRwEn <= 0;  expFrwEn <= 0;  pending <= 0;
      end else begin
         expRwEn  <= 0;
         expFrwEn <= 0;
         curI = pending ? pendInstr : sampleInputs();
         if ((pending && bus.mem_rvalid) ||
             (!pending && bus.in_valid && (!curI.memToReg || bus.mem_rvalid))) begin
            expBusW    <= intResult(curI, bus.mem_rdata);
            expFbusW   <= fpResult(curI, bus.mem_rdata);
            expRwAddr  <= curI.rd;
            expFrwAddr <= curI.frd;
            expRwEn    <= curI.regWr && (curI.rd != 0);
            expFrwEn   <= curI.fregWr;
            pending    <= 0;
         end else if (!pending && bus.in_valid) begin
            pendInstr <= curI;
            pending   <= 1;
         end
      end
   end

   // Compare every cycle, away from the active edge.
   always @(negedge clk) begin
      if (chkOn) begin
         cmp("busW", bus.busW, expBusW);
         cmp("fbusW", bus.fbusW, expFbusW);
         cmp("rw_addr", 32'(bus.rw_addr), 32'(expRwAddr));
         cmp("frw_addr", 32'(bus.frw_addr), 32'(expFrwAddr));
         cmp("rw_en", 32'(bus.rw_en), 32'(expRwEn));
         cmp("frw_en", 32'(bus.frw_en), 32'(expFrwEn));
         cmp("in_ready", 32'(bus.in_ready), 32'(!pending));
         cmp("wb_busy", 32'(bus.wb_busy), 32'(pending));
      end
   end

   // ---------------- stimulus ----------------
   function automatic instr_t blank();
      instr_t i = '0;
      i.sz = 2'b10;
      return i;
   endfunction

   task automatic drive(input logic v, input instr_t i);
      bus.in_valid = v;
      bus.alu_out = i.alu;   bus.fpu_out = i.fpu;
      bus.bus_a = i.busA;    bus.fbus_a = i.fbusA;  bus.jal_out = i.jal;
      bus.rd = i.rd;         bus.frd = i.frd;
      bus.reg_wr = i.regWr;  bus.freg_wr = i.fregWr;
      bus.mem_to_reg = i.memToReg; bus.mov_instr = i.mov; bus.jal_ctrl = i.jalC;
      bus.ld_size = i.sz;    bus.ld_signed = i.sgn;  bus.ld_addr_lo = i.lo;
   endtask

   task automatic mem(input logic v, input logic [31:0] d);
      bus.mem_rvalid = v;
      bus.mem_rdata  = d;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   typedef struct packed {
      logic [1:0]  sz;
      logic        sgn;
      logic [1:0]  lo;
      logic [31:0] data;
      logic [31:0] exp;
   } ldvec_t;

   ldvec_t ldTab [9] = '{
      '{2'b00, 1'b1, 2'd0, 32'h8899AABB, 32'hFFFFFF88},
      '{2'b00, 1'b0, 2'd3, 32'h8899AABB, 32'h000000BB},
      '{2'b00, 1'b1, 2'd2, 32'h8899AABB, 32'hFFFFFFAA},
      '{2'b00, 1'b0, 2'd1, 32'h8899AABB, 32'h00000099},
      '{2'b01, 1'b1, 2'd1, 32'h8899AABB, 32'hFFFF8899},
      '{2'b01, 1'b0, 2'd3, 32'h8899AABB, 32'h0000AABB},
      '{2'b01, 1'b1, 2'd2, 32'h12347FFF, 32'h00007FFF},
      '{2'b11, 1'b1, 2'd1, 32'h8899AABB, 32'h8899AABB},
      '{2'b10, 1'b0, 2'd0, 32'hCAFEF00D, 32'hCAFEF00D}
   };

   initial begin
      instr_t i;
      rst_n = 1'b1;
      drive(1'b0, blank());
      mem(1'b0, 32'h0);
      #1 rst_n = 1'b0;
      #2 chkOn = 1;
      cmp("reset busW", bus.busW, 32'h0);
      cmp("reset rw_en", 32'(bus.rw_en), 32'h0);
      cmp("reset wb_busy", 32'(bus.wb_busy), 32'h0);
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      #1 cmp("ready after reset", 32'(bus.in_ready), 32'h1);

      // ALU op
      tick();
      i = blank(); i.alu = 32'h5; i.rd = 5'd3; i.regWr = 1;
      drive(1'b1, i);
      tick();
      drive(1'b0, blank());
      cmp("alu busW", bus.busW, 32'h5);
      cmp("alu rw_addr", 32'(bus.rw_addr), 32'd3);
      cmp("alu rw_en", 32'(bus.rw_en), 32'h1);
      tick();
      cmp("alu rw_en drop", 32'(bus.rw_en), 32'h0);

      // Signed byte load, data three cycles late; a new op is offered during the stall
      i = blank(); i.memToReg = 1; i.regWr = 1; i.rd = 5'd4; i.sz = 2'b00; i.sgn = 1; i.lo = 2'd1;
      drive(1'b1, i);
      mem(1'b0, 32'hDEADBEEF);
      tick();
      i = blank(); i.alu = 32'h77; i.rd = 5'd9; i.regWr = 1;
      drive(1'b1, i);
      cmp("stall1 in_ready", 32'(bus.in_ready), 32'h0);
      cmp("stall1 wb_busy", 32'(bus.wb_busy), 32'h1);
      tick();
      cmp("stall2 wb_busy", 32'(bus.wb_busy), 32'h1);
      tick();
      cmp("stall3 wb_busy", 32'(bus.wb_busy), 32'h1);
      drive(1'b0, blank());
      mem(1'b1, 32'h12F45678);
      tick();
      mem(1'b0, 32'h0);
      cmp("sbyte busW", bus.busW, 32'hFFFFFFF4);
      cmp("sbyte rw_en", 32'(bus.rw_en), 32'h1);
      cmp("sbyte in_ready", 32'(bus.in_ready), 32'h1);

      // Unsigned half load, data present at accept
      i = blank(); i.memToReg = 1; i.regWr = 1; i.rd = 5'd6; i.sz = 2'b01; i.lo = 2'd2;
      drive(1'b1, i);
      mem(1'b1, 32'h1234ABCD);
      tick();
      drive(1'b0, blank());
      mem(1'b0, 32'h0);
      cmp("uhalf busW", bus.busW, 32'h0000ABCD);
      cmp("uhalf no stall", 32'(bus.in_ready), 32'h1);

      // Cross-file swap
      i = blank(); i.mov = 1; i.regWr = 1; i.fregWr = 1; i.rd = 5'd7; i.frd = 5'd9;
      i.busA = 32'hAAAA0000; i.fbusA = 32'h0000BBBB; i.alu = 32'h1; i.fpu = 32'h2;
      drive(1'b1, i);
      tick();
      drive(1'b0, blank());
      cmp("mov busW", bus.busW, 32'h0000BBBB);
      cmp("mov fbusW", bus.fbusW, 32'hAAAA0000);
      cmp("mov rw_en", 32'(bus.rw_en), 32'h1);
      cmp("mov frw_en", 32'(bus.frw_en), 32'h1);

      // Link write to r0: data lands, strobe suppressed
      i = blank(); i.jalC = 1; i.memToReg = 1; i.regWr = 1; i.rd = 5'd0; i.jal = 32'h40;
      drive(1'b1, i);
      mem(1'b1, 32'h11111111);
      tick();
      drive(1'b0, blank());
      mem(1'b0, 32'h0);
      cmp("jal busW", bus.busW, 32'h40);
      cmp("jal rw_en r0", 32'(bus.rw_en), 32'h0);

      // Spurious mem_rvalid in IDLE
      mem(1'b1, 32'h99999999);
      tick();
      mem(1'b0, 32'h0);
      cmp("spurious rw_en", 32'(bus.rw_en), 32'h0);
      cmp("spurious busW hold", bus.busW, 32'h40);

      // Back-to-back, including an FP load into f0
      for (int k = 1; k <= 3; k++) begin
         i = blank(); i.alu = 32'(k * 11); i.rd = 5'(k); i.regWr = 1;
         drive(1'b1, i);
         tick();
         cmp("b2b busW", bus.busW, 32'(k * 11));
         cmp("b2b rw_en", 32'(bus.rw_en), 32'h1);
      end
      i = blank(); i.memToReg = 1; i.fregWr = 1; i.frd = 5'd0; i.sz = 2'b00; i.fpu = 32'h5;
      drive(1'b1, i);
      mem(1'b1, 32'h80706050);
      tick();
      drive(1'b0, blank());
      mem(1'b0, 32'h0);
      cmp("fp load fbusW", bus.fbusW, 32'h80706050);
      cmp("fp load frw_en f0", 32'(bus.frw_en), 32'h1);
      cmp("fp load rw_en", 32'(bus.rw_en), 32'h0);

      // Load extraction table
      foreach (ldTab[k]) begin
         i = blank(); i.memToReg = 1; i.regWr = 1; i.rd = 5'd5;
         i.sz = ldTab[k].sz; i.sgn = ldTab[k].sgn; i.lo = ldTab[k].lo;
         drive(1'b1, i);
         mem(1'b1, ldTab[k].data);
         tick();
         cmp("load table busW", bus.busW, ldTab[k].exp);
      end
      drive(1'b0, blank());
      mem(1'b0, 32'h0);
      tick();

      // Reset while a load waits: discarded, late data writes nothing
      i = blank(); i.memToReg = 1; i.regWr = 1; i.rd = 5'd8;
      drive(1'b1, i);
      tick();
      drive(1'b0, blank());
      cmp("pre-reset wb_busy", 32'(bus.wb_busy), 32'h1);
      rst_n = 1'b0;
      #2;
      cmp("mid reset busW", bus.busW, 32'h0);
      cmp("mid reset rw_addr", 32'(bus.rw_addr), 32'h0);
      cmp("mid reset wb_busy", 32'(bus.wb_busy), 32'h0);
      #4 rst_n = 1'b1;
      mem(1'b1, 32'h55555555);
      tick();
      mem(1'b0, 32'h0);
      cmp("late data rw_en", 32'(bus.rw_en), 32'h0);
      cmp("late data busW", bus.busW, 32'h0);
      cmp("after reset in_ready", 32'(bus.in_ready), 32'h1);
      tick();
      tick();

      chkOn = 0;
      $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
      $finish;
   end
endmodule

// File: doc/wb_pipe.md
Name: wb_pipe

Overview:
Parametrised, registered write-back stage for the pipelined processor. It replaces the purely combinational integer/FP write-back select with a clocked stage. The stage accepts one retiring instruction per cycle from MEM and waits, with a stall, for late memory read data. It extracts and extends sub-word loads, then drives the integer and FP register-file write ports one cycle after it has all the data.

Parameters:
WIDTH, 32, datapath width; a multiple of 16.
RADDR, 5, register-file address width for both the integer and FP files.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  MEM stage presents an instruction
in_ready  out  1  stage can accept; high only in IDLE
alu_out  in  WIDTH  integer ALU result
fpu_out  in  WIDTH  FPU result
bus_a  in  WIDTH  integer source A, used for int-to-FP move
fbus_a  in  WIDTH  FP source A, used for FP-to-int move
jal_out  in  WIDTH  link address
rd  in  RADDR  integer destination
frd  in  RADDR  FP destination
reg_wr  in  1  instruction writes the integer file
freg_wr  in  1  instruction writes the FP file
mem_to_reg  in  1  result comes from memory (load)
mov_instr  in  1  cross-file move
jal_ctrl  in  1  link write
ld_size  in  2  00 byte, 01 half, 10 word; 11 is treated as word
ld_signed  in  1  sign-extend sub-word loads
ld_addr_lo  in  2  low bits of the load address
mem_rvalid  in  1  memory read data valid
mem_rdata  in  WIDTH  memory read data
busW  out  WIDTH  integer write data
fbusW  out  WIDTH  FP write data
rw_addr  out  RADDR  integer write address
frw_addr  out  RADDR  FP write address
rw_en  out  1  integer write strobe, one cycle
frw_en  out  1  FP write strobe, one cycle
wb_busy  out  1  high in WAIT_MEM

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - busW, fbusW, rw_addr and frw_addr are 0.
  - rw_en, frw_en and wb_busy are 0.
  - in_ready is 1 after release.
- Reset mid-WAIT_MEM: the pending load is discarded and no write occurs.
- Accept: an instruction is accepted when in_valid and in_ready are both high in the same cycle (cycle t). All inputs are captured at t.
- State machine: IDLE and WAIT_MEM.
  - IDLE, accept of a non-load, or a load with mem_rvalid=1 at t: write ports update at t+1 and the stage stays in IDLE.
  - IDLE, accept of a load with mem_rvalid=0: go to WAIT_MEM. in_ready=0 and wb_busy=1.
  - WAIT_MEM, mem_rvalid=1 at cycle u: mem_rdata is captured and the write ports update at u+1. The stage returns to IDLE at u+1, so in_ready=1 at u+1.
  - mem_rvalid while IDLE with no load accepted is ignored.
- Integer write data priority: jal_ctrl, then mov_instr (fbus_a), then mem_to_reg (extended load), then alu_out.
- FP write data priority: mov_instr (bus_a), then mem_to_reg (full mem_rdata word, ld_size ignored), then fpu_out.
- Load extraction uses big-endian lane order; byte lane 0 is the most significant byte.
  - Byte: lane ld_addr_lo.
  - Half: halfword ld_addr_lo[1]; ld_addr_lo[0] is ignored.
  - The extracted value is zero-extended, or sign-extended when ld_signed=1.
- Write strobes:
  - rw_en = reg_wr and rd≠0. A write to register 0 is suppressed; busW and rw_addr still update.
  - frw_en = freg_wr; FP register 0 is writable.
  - Both strobes are high for exactly one cycle per accepted instruction.
  - With no accept, both strobes are 0 and the data and address outputs hold their last values.
- A move with reg_wr and freg_wr both set swaps values between the files in one write cycle.
- Back-to-back accepts in IDLE give one write per cycle, with no bubbles.

Test Plan:
- Reset, then an ALU op: alu_out=0x00000005, rd=3, reg_wr=1 accepted at t -> at t+1 busW=0x00000005, rw_addr=3, rw_en=1; at t+2 rw_en=0.
- Signed byte load: ld_size=00, ld_signed=1, ld_addr_lo=1. mem_rdata=0x12F45678 arrives 3 cycles after accept -> in_ready=0 and wb_busy=1 for 3 cycles; busW=0xFFFFFFF4 one cycle after mem_rvalid.
- Unsigned half load: ld_addr_lo=2, mem_rdata=0x1234ABCD with mem_rvalid at accept -> busW=0x0000ABCD at t+1 and no stall.
- Move with reg_wr=freg_wr=1, bus_a=0xAAAA0000, fbus_a=0x0000BBBB -> busW=0x0000BBBB and fbusW=0xAAAA0000, rw_en=frw_en=1 in the same cycle.
- jal_ctrl=1, mem_to_reg=1, rd=0, jal_out=0x40 -> busW=0x40 and rw_en=0 (rd=0 suppressed).
- Load pending in WAIT_MEM, rst_n pulsed low -> immediate outputs 0 and in_ready=1 after release; the late mem_rvalid produces no write.
